// File: rtl/cpu_trace_monitor.sv
// cpu_trace_monitor: captures WB/MEM commit events into a FWFT FIFO and
// streams them over valid/ready, with run counters and halt/timeout stop.
module cpu_trace_monitor #(
  parameter int         DW      = 16,
  parameter int         AW      = 16,
  parameter int         RW      = 4,
  parameter int         DEPTH   = 16,
  parameter int         CW      = 32,
  parameter int         TIMEOUT = 100000,
  parameter logic [3:0] MASK    = 4'hF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [DW-1:0]                pc,
  input  logic                         reg_write,
  input  logic [RW-1:0]                write_reg,
  input  logic [DW-1:0]                write_data,
  input  logic                         mem_read,
  input  logic                         mem_write,
  input  logic [AW-1:0]                mem_addr,
  input  logic [DW-1:0]                mem_wdata,
  input  logic [DW-1:0]                mem_rdata,
  input  logic                         halt,
  output logic                         trace_valid,
  input  logic                         trace_ready,
  output logic [4+RW+2*DW+AW+CW-1:0]   trace_rec,
  output logic [CW-1:0]                cycle_count,
  output logic [CW-1:0]                inst_count,
  output logic [CW-1:0]                drop_count,
  output logic                         overflow,
  output logic                         timeout,
  output logic                         done
);

  localparam int AWP  = $clog2(DEPTH);
  localparam int PW   = AWP + 1;
  localparam int RECW = 4 + RW + 2*DW + AW + CW;
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST_FREE = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [RECW-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_cyc;
  logic [CW-1:0]   r_inst;
  logic [CW-1:0]   r_drop;
  logic            r_ovf;
  logic            r_tmo;
  logic            r_done;

  logic [PW-1:0]   w_count;
  logic            w_empty;
  logic            w_run;
  logic [3:0]      w_flags;
  logic            w_event;
  logic            w_admit;
  logic            w_push;
  logic            w_drop;
  logic            w_pop;
  logic            w_commit;
  logic            w_tmo_hit;
  logic [DW-1:0]   w_mdata;
  logic [RECW-1:0] w_rec;
  logic            w_unused;

  assign w_count   = r_wptr - r_rptr;
  assign w_empty   = (w_count == '0);
  assign w_run     = (r_state == S_RUN);
  assign w_flags   = {halt,
                      mem_write & MASK[2],
                      mem_read  & MASK[1],
                      reg_write & MASK[0]};
  assign w_event   = |w_flags;
  assign w_mdata   = mem_write ? mem_wdata : mem_rdata;
  assign w_rec     = {w_flags, write_reg, write_data,
                      mem_addr, w_mdata, r_cyc};
  // last slot is held back so a halt record always fits
  assign w_admit   = w_flags[3] | (w_count < LAST_FREE);
  assign w_push    = w_run & w_event & w_admit;
  assign w_drop    = w_run & w_event & ~w_admit;
  assign w_pop     = ~w_empty & trace_ready;
  assign w_commit  = halt | reg_write | mem_write;
  assign w_tmo_hit = (r_cyc == TMO_LAST);
  assign w_unused  = ^pc;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AWP-1:0]] <= w_rec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cyc   <= '0;
      r_inst  <= '0;
      r_drop  <= '0;
      r_ovf   <= 1'b0;
      r_tmo   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
        if (r_drop != '1) begin
          r_drop <= r_drop + CW'(1);
        end
      end
      if (w_run) begin
        if (r_cyc != '1) begin
          r_cyc <= r_cyc + CW'(1);
        end
        if (w_commit && (r_inst != '1)) begin
          r_inst <= r_inst + CW'(1);
        end
      end
      unique case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (halt || w_tmo_hit) begin
            r_state <= S_DRAIN;
          end
          if (w_tmo_hit) begin
            r_tmo <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (w_empty) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  assign trace_valid = ~w_empty;
  assign trace_rec   = w_empty ? '0 : r_mem[r_rptr[AWP-1:0]];
  assign cycle_count = r_cyc;
  assign inst_count  = r_inst;
  assign drop_count  = r_drop;
  assign overflow    = r_ovf;
  assign timeout     = r_tmo;
  assign done        = r_done;

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Bench for cpu_trace_monitor: scoreboard of expected trace records,
// checked as the DUT hands them over on valid&ready.
module tb_cpu_trace_monitor;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] pc = '0;
  logic        reg_write = 1'b0;
  logic [3:0]  write_reg = '0;
  logic [15:0] write_data = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] mem_wdata = '0;
  logic [15:0] mem_rdata = '0;
  logic        halt = 1'b0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic [87:0] trace_rec;
  logic [31:0] cycle_count;
  logic [31:0] inst_count;
  logic [31:0] drop_count;
  logic        overflow;
  logic        timeout;
  logic        done;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_pops = 0;
  logic [87:0] exp_q[$];
  logic [87:0] mon_e;
  int          m_cnt = 0;
  int          m_cyc = 0;
  int          m_inst = 0;
  int          m_drop = 0;
  bit          m_run = 0;
  bit          m_tmo = 0;

  always #5 clk = ~clk;

  cpu_trace_monitor #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .pc(pc),
    .reg_write(reg_write), .write_reg(write_reg),
    .write_data(write_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .halt(halt), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_rec(trace_rec),
    .cycle_count(cycle_count), .inst_count(inst_count),
    .drop_count(drop_count), .overflow(overflow),
    .timeout(timeout), .done(done)
  );

  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (trace_valid !== (m_cnt != 0)) begin
        n_bad++;
        $display("FAIL valid: got %b want %b", trace_valid, m_cnt != 0);
      end
      if (trace_valid && trace_ready) begin
        n_cmp++;
        n_pops++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL rec: got %h want <none>", trace_rec);
        end else begin
          mon_e = exp_q.pop_front();
          if (trace_rec !== mon_e) begin
            n_bad++;
            $display("FAIL rec: got %h want %h", trace_rec, mon_e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  task automatic clr_in;
    reg_write = 0; write_reg = '0; write_data = '0;
    mem_read = 0; mem_write = 0; mem_addr = '0;
    mem_wdata = '0; mem_rdata = '0; halt = 0;
  endtask

  task automatic step(input bit rw, input logic [3:0] wr,
                      input logic [15:0] wd, input bit mr,
                      input bit mw, input logic [15:0] ma,
                      input logic [15:0] wdat,
                      input logic [15:0] rdat, input bit h);
    logic [3:0]  f;
    logic [87:0] r;
    bit          pp;
    bit          psh;
    reg_write = rw; write_reg = wr; write_data = wd;
    mem_read = mr; mem_write = mw; mem_addr = ma;
    mem_wdata = wdat; mem_rdata = rdat; halt = h;
    pc = pc + 16'd2;
    f   = {h, mw, mr, rw};
    r   = {f, wr, wd, ma, mw ? wdat : rdat, 32'(m_cyc)};
    pp  = (m_cnt > 0) && trace_ready;
    psh = 0;
    @(posedge clk); #1;
    if (m_run) begin
      if (f != 4'b0) begin
        if (h || m_cnt < 15) begin
          psh = 1;
          exp_q.push_back(r);
        end else begin
          m_drop++;
        end
      end
      if (h | rw | mw) m_inst++;
      if (m_cyc == TMO - 1) m_tmo = 1;
      if (h || m_cyc == TMO - 1) m_run = 0;
      m_cyc++;
    end
    m_cnt = m_cnt + int'(psh) - int'(pp);
    clr_in();
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 4'd0, 16'd0, 0, 0, 16'd0, 16'd0, 16'd0, 0);
  endtask

  task automatic do_reset;
    rst = 1;
    clr_in();
    enable = 0;
    trace_ready = 0;
    exp_q.delete();
    m_cnt = 0; m_cyc = 0; m_inst = 0; m_drop = 0;
    m_run = 0; m_tmo = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic start;
    enable = 1;
    @(posedge clk); #1;
    enable = 0;
    m_run = 1;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
      idle(1);
    end
  endtask

  task automatic test_reset;
    do_reset();
    n_cmp++;
    if ({trace_valid, overflow, timeout, done} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_flags: got %b want 0000",
               {trace_valid, overflow, timeout, done});
    end
    n_cmp++;
    if ({cycle_count, inst_count, drop_count} !== 96'b0) begin
      n_bad++;
      $display("FAIL rst_cnt: got %h/%h/%h want 0", cycle_count,
               inst_count, drop_count);
    end
    n_cmp++;
    if (trace_rec !== 88'b0) begin
      n_bad++;
      $display("FAIL rst_rec: got %h want 0", trace_rec);
    end
  endtask

  task automatic test_single;
    bit ok;
    do_reset();
    trace_ready = 1;
    start();
    idle(2);
    step(1, 4'd3, 16'h00AB, 0, 0, 16'h0, 16'h0, 16'h0, 0);
    n_cmp++;
    if (inst_count !== 32'd1) begin
      n_bad++;
      $display("FAIL t1_inst: got %0d want 1", inst_count);
    end
    step(0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1);
    wait_done(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL t1_done: got %b want 1", done);
    end
    n_cmp++;
    if (cycle_count !== 32'd4 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL t1_end: got cyc=%0d left=%0d want 4/0",
               cycle_count, exp_q.size());
    end
  endtask

  task automatic test_mem;
    bit ok;
    do_reset();
    trace_ready = 1;
    start();
    step(0, 4'd0, 16'h0, 0, 1, 16'h0040, 16'h1234, 16'hDEAD, 0);
    step(0, 4'd0, 16'h0, 1, 0, 16'h0040, 16'h5555, 16'h1234, 0);
    n_cmp++;
    if (inst_count !== 32'd1) begin
      n_bad++;
      $display("FAIL t2_inst: got %0d want 1", inst_count);
    end
    step(0, 4'd0, 16'h0, 1, 1, 16'h0044, 16'h7777, 16'h8888, 0);
    step(0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1);
    wait_done(ok);
    n_cmp++;
    if (!ok || inst_count !== 32'd3 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL t2_end: got done=%b inst=%0d left=%0d want 1/3/0",
               done, inst_count, exp_q.size());
    end
  endtask

  task automatic test_overflow;
    bit ok;
    int p0;
    do_reset();
    start();
    for (int i = 0; i < 20; i++)
      step(1, 4'(i), 16'h0100 + 16'(i), 0, 0, 16'h0, 16'h0, 16'h0, 0);
    n_cmp++;
    if (drop_count !== 32'd5 || overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL t3_drop: got %0d/%b want 5/1", drop_count, overflow);
    end
    step(0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1);
    n_cmp++;
    if (drop_count !== 32'd5 || inst_count !== 32'd21) begin
      n_bad++;
      $display("FAIL t3_halt: got drop=%0d inst=%0d want 5/21",
               drop_count, inst_count);
    end
    p0 = n_pops;
    trace_ready = 1;
    wait_done(ok);
    n_cmp++;
    if (!ok || n_pops - p0 != 16 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL t3_drain: got done=%b pops=%0d want 1/16",
               done, n_pops - p0);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    do_reset();
    start();
    for (int i = 0; i < 15; i++)
      step(1, 4'(i), 16'h0200 + 16'(i), 0, 0, 16'h0, 16'h0, 16'h0, 0);
    trace_ready = 1;
    step(1, 4'd7, 16'hBEEF, 0, 0, 16'h0, 16'h0, 16'h0, 0);
    n_cmp++;
    if (drop_count !== 32'd1) begin
      n_bad++;
      $display("FAIL bb_drop1: got %0d want 1", drop_count);
    end
    step(1, 4'd8, 16'hCAFE, 0, 0, 16'h0, 16'h0, 16'h0, 0);
    n_cmp++;
    if (drop_count !== 32'd1) begin
      n_bad++;
      $display("FAIL bb_drop2: got %0d want 1", drop_count);
    end
    step(0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1);
    wait_done(ok);
    n_cmp++;
    if (!ok || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL bb_end: got done=%b left=%0d want 1/0",
               done, exp_q.size());
    end
  endtask

  task automatic test_halt_drain;
    bit ok;
    int p0;
    do_reset();
    start();
    for (int i = 0; i < 3; i++)
      step(1, 4'(i + 1), 16'h0300 + 16'(i), 0, 0, 16'h0, 16'h0, 16'h0, 0);
    trace_ready = 1;
    p0 = n_pops;
    step(0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1);
    wait_done(ok);
    n_cmp++;
    if (!ok || n_pops - p0 != 4) begin
      n_bad++;
      $display("FAIL t4_drain: got done=%b pops=%0d want 1/4",
               done, n_pops - p0);
    end
    for (int i = 0; i < 3; i++)
      step(1, 4'd9, 16'h9999, 1, 1, 16'h0, 16'h1, 16'h2, 1);
    n_cmp++;
    if (done !== 1'b1 || cycle_count !== 32'd4 || inst_count !== 32'd4) begin
      n_bad++;
      $display("FAIL t4_ignore: got done=%b cyc=%0d inst=%0d want 1/4/4",
               done, cycle_count, inst_count);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    do_reset();
    trace_ready = 1;
    start();
    for (int i = 0; i < TMO; i++)
      step(i % 10 == 9, 4'd5, 16'(i), 0, 0, 16'h0, 16'h0, 16'h0, 0);
    n_cmp++;
    if (timeout !== 1'b1 || cycle_count !== 32'd50 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL t5_tmo: got tmo=%b cyc=%0d done=%b want 1/50/0",
               timeout, cycle_count, done);
    end
    wait_done(ok);
    idle(2);
    n_cmp++;
    if (!ok || cycle_count !== 32'd50 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL t5_done: got done=%b cyc=%0d want 1/50",
               done, cycle_count);
    end
  endtask

  task automatic test_timeout_halt;
    bit ok;
    do_reset();
    trace_ready = 1;
    start();
    idle(TMO - 1);
    step(0, 4'd0, 16'h0, 0, 0, 16'h0, 16'h0, 16'h0, 1);
    wait_done(ok);
    n_cmp++;
    if (timeout !== 1'b1 || !ok || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL th_end: got tmo=%b done=%b left=%0d want 1/1/0",
               timeout, done, exp_q.size());
    end
  endtask

  task automatic test_rst_mid;
    do_reset();
    start();
    for (int i = 0; i < 5; i++)
      step(1, 4'(i), 16'h0500 + 16'(i), 0, 0, 16'h0, 16'h0, 16'h0, 0);
    n_cmp++;
    if (trace_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL t6_pre: got %b want 1", trace_valid);
    end
    #2 rst = 1;
    exp_q.delete();
    m_cnt = 0; m_cyc = 0; m_inst = 0; m_drop = 0; m_run = 0;
    #1;
    n_cmp++;
    if ({trace_valid, done} !== 2'b0 ||
        {cycle_count, inst_count, drop_count} !== 96'b0) begin
      n_bad++;
      $display("FAIL t6_rst: got v=%b cyc=%0d inst=%0d want 0",
               trace_valid, cycle_count, inst_count);
    end
    @(posedge clk); #1 rst = 0;
    step(1, 4'd2, 16'h1111, 0, 0, 16'h0, 16'h0, 16'h0, 0);
    n_cmp++;
    if (trace_valid !== 1'b0 || cycle_count !== 32'd0) begin
      n_bad++;
      $display("FAIL t6_idle: got v=%b cyc=%0d want 0/0",
               trace_valid, cycle_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mem();
    test_overflow();
    test_back_to_back();
    test_halt_drain();
    test_timeout();
    test_timeout_halt();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
